sdram_read: RTL and testbench

- Read-side counterpart of the SDRAM write controller.
- On a request it performs one single-beat read burst:
  - ACTIVE the current row.
  - Wait tRCD.
  - Issue READ with auto-precharge (A10=1).
  - Capture the 32-bit DQ word after CAS latency.
  - Hold off until tRC has elapsed, then pulse done.
- Walks column → row → bank sequentially, mirroring the writer's address order.
- Its command/address outputs are muxed by the top-level SDRAM arbiter alongside the write and refresh blocks.

---
 rtl/sdram_pkg.sv | 30 +++
 rtl/sdram_addr_gen.sv | 32 +++
 rtl/sdram_read.sv | 104 ++++++++++
 tb/tb_sdram_read.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the read, write and refresh controllers:
// command encodings, default timing, and the read FSM state type.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;

    // A10 high on READ/WRITE selects auto-precharge
    localparam int A10_BIT = 10;

    localparam int DEF_TRCD    = 3;
    localparam int DEF_CAS_LAT = 3;
    localparam int DEF_TRC     = 10;
    localparam int DEF_COL_W   = 8;
    localparam int DEF_ROW_W   = 11;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_TRCD_WAIT,
        RD_READ,
        RD_CL_WAIT,
        RD_TRC_WAIT
    } rd_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Sequential column -> row -> bank address walker; one step per inc pulse.
module sdram_addr_gen
    import sdram_pkg::*;
#(
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [1:0]       bank
);

    // Each wrap carries into the next field in the same cycle; bank wraps silently.
    always_ff @(posedge sclk) begin
        if (srst) begin
            col  <= '0;
            row  <= '0;
            bank <= '0;
        end else if (inc) begin
            col <= col + 1'b1;
            if (&col) begin
                row <= row + 1'b1;
                if (&row)
                    bank <= bank + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_read.sv
// Single-beat SDRAM read controller: ACTIVE, READ with auto-precharge,
// capture after CAS latency, then hold until tRC before signalling done.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int TRCD    = DEF_TRCD,
    parameter int CAS_LAT = DEF_CAS_LAT,
    parameter int TRC     = DEF_TRC,
    parameter int COL_W   = DEF_COL_W,
    parameter int ROW_W   = DEF_ROW_W
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             rd_en,
    output logic             rd_done,
    input  logic [31:0]      i_rd_dq,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_valid,
    output logic [ROW_W-1:0] o_rd_addr,
    output logic [1:0]       o_rd_ba,
    output logic [3:0]       o_rd_dqm,
    output logic             o_rd_cs_n,
    output logic             o_rd_ras_n,
    output logic             o_rd_cas_n,
    output logic             o_rd_we_n
);

    localparam int CNT_W = $clog2(TRC + 1);
    localparam logic [CNT_W-1:0] K_READ = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] K_CAPT = CNT_W'(TRCD + CAS_LAT);
    localparam logic [CNT_W-1:0] K_DONE = CNT_W'(TRC - 2);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(TRC - 1);
    localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << A10_BIT;

    rd_state_e        state;
    logic [CNT_W-1:0] trc_cnt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [1:0]       bank;
    logic [3:0]       cmd;

    sdram_addr_gen #(.COL_W(COL_W), .ROW_W(ROW_W)) u_addr (
        .sclk (sclk),
        .srst (srst),
        .inc  (state == RD_READ),
        .col  (col),
        .row  (row),
        .bank (bank)
    );

    // trc_cnt is 0 in the ACTIVE cycle, so it equals the offset from ACTIVE.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state      <= RD_IDLE;
            trc_cnt    <= '0;
            rd_done    <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_done    <= 1'b0;
            o_rd_valid <= 1'b0;
            trc_cnt    <= (state == RD_IDLE) ? '0 : trc_cnt + 1'b1;
            if ((state == RD_CL_WAIT || state == RD_TRC_WAIT) && trc_cnt == K_DONE)
                rd_done <= 1'b1;
            case (state)
                RD_IDLE:      if (rd_en) state <= RD_ACTIVE;
                RD_ACTIVE:    state <= RD_TRCD_WAIT;
                RD_TRCD_WAIT: if (trc_cnt == K_READ) state <= RD_READ;
                RD_READ:      state <= RD_CL_WAIT;
                RD_CL_WAIT: begin
                    if (trc_cnt == K_CAPT) begin
                        o_rd_data  <= i_rd_dq;
                        o_rd_valid <= 1'b1;
                        state      <= RD_TRC_WAIT;
                    end
                end
                RD_TRC_WAIT:  if (trc_cnt == K_LAST) state <= RD_IDLE;
                default:      state <= RD_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd       = CMD_NOP;
        o_rd_addr = ADDR_A10;
        case (state)
            RD_IDLE:   cmd = CMD_INHIBIT;
            RD_ACTIVE: begin
                cmd       = CMD_ACTIVE;
                o_rd_addr = row;
            end
            RD_READ: begin
                cmd       = CMD_READ;
                o_rd_addr = ADDR_A10 | ROW_W'(col);
            end
            default:   cmd = CMD_NOP;
        endcase
    end

    assign {o_rd_cs_n, o_rd_ras_n, o_rd_cas_n, o_rd_we_n} = cmd;
    assign o_rd_ba  = bank;
    assign o_rd_dqm = 4'b0000;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: CAS_LAT=3 and CAS_LAT=2 builds against an offset-based
// access model, directed timeline/wrap/reset cases, and a small addr_gen wrap check.
module tb_sdram_read;

    localparam int TRCD = 3;
    localparam int TRC  = 10;

    logic        sclk = 1'b0;
    logic        srst = 1'b1;
    logic        rd_en = 1'b0;
    logic [31:0] dq = '0;
    logic        ag_inc = 1'b0;

    logic        done   [2];
    logic        valid  [2];
    logic [31:0] data   [2];
    logic [10:0] addr   [2];
    logic [1:0]  ba     [2];
    logic [3:0]  dqm    [2];
    logic        cs_n   [2];
    logic        ras_n  [2];
    logic        cas_n  [2];
    logic        we_n   [2];
    logic        ag_col, ag_row;
    logic [1:0]  ag_bank;

    sdram_read #(.CAS_LAT(3)) u_dut_cl3 (
        .sclk(sclk), .srst(srst), .rd_en(rd_en), .rd_done(done[0]), .i_rd_dq(dq),
        .o_rd_data(data[0]), .o_rd_valid(valid[0]), .o_rd_addr(addr[0]), .o_rd_ba(ba[0]),
        .o_rd_dqm(dqm[0]), .o_rd_cs_n(cs_n[0]), .o_rd_ras_n(ras_n[0]),
        .o_rd_cas_n(cas_n[0]), .o_rd_we_n(we_n[0]));

    sdram_read #(.CAS_LAT(2)) u_dut_cl2 (
        .sclk(sclk), .srst(srst), .rd_en(rd_en), .rd_done(done[1]), .i_rd_dq(dq),
        .o_rd_data(data[1]), .o_rd_valid(valid[1]), .o_rd_addr(addr[1]), .o_rd_ba(ba[1]),
        .o_rd_dqm(dqm[1]), .o_rd_cs_n(cs_n[1]), .o_rd_ras_n(ras_n[1]),
        .o_rd_cas_n(cas_n[1]), .o_rd_we_n(we_n[1]));

    sdram_addr_gen #(.COL_W(1), .ROW_W(1)) u_ag (
        .sclk(sclk), .srst(srst), .inc(ag_inc), .col(ag_col), .row(ag_row), .bank(ag_bank));

    always #5 sclk = ~sclk;

    int tests = 0;
    int fails = 0;
    int t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
        end
    endtask

    function automatic logic [3:0] cmd_of(input int i);
        return {cs_n[i], ras_n[i], cas_n[i], we_n[i]};
    endfunction

    // Model: an access is a cycle offset k from ACTIVE; the address is one linear
    // index of 21 bits = {bank, row[10:0], col[7:0]} advanced once per access.
    int          cl_of [2] = '{3, 2};
    bit          m_init = 1'b0;
    bit          m_busy [2];
    int          m_k    [2];
    int unsigned m_idx  [2];
    logic [31:0] m_data [2];
    bit          m_valid[2];
    bit          m_done [2];

    always @(posedge sclk) begin
        for (int i = 0; i < 2; i++) begin
            if (srst) begin
                m_busy[i] = 0; m_k[i] = 0; m_idx[i] = 0;
                m_data[i] = '0; m_valid[i] = 0; m_done[i] = 0;
            end else begin
                m_valid[i] = 0;
                m_done[i]  = 0;
                if (!m_busy[i]) begin
                    if (rd_en) begin m_busy[i] = 1; m_k[i] = 0; end
                end else begin
                    if (m_k[i] == TRCD) m_idx[i] = (m_idx[i] + 1) % (1 << 21);
                    if (m_k[i] == TRCD + cl_of[i]) begin m_data[i] = dq; m_valid[i] = 1; end
                    if (m_k[i] == TRC - 2) m_done[i] = 1;
                    if (m_k[i] == TRC - 1) m_busy[i] = 0;
                    else m_k[i]++;
                end
            end
        end
        if (srst) m_init = 1'b1;
    end

    always @(negedge sclk) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0]  ec;
                logic [10:0] ea;
                ea = 11'h400;
                if (!m_busy[i])            ec = 4'b1111;
                else if (m_k[i] == 0)    begin ec = 4'b0011; ea = 11'((m_idx[i] >> 8) & 32'h7FF); end
                else if (m_k[i] == TRCD) begin ec = 4'b0101; ea = 11'h400 | 11'(m_idx[i] & 32'hFF); end
                else                       ec = 4'b0111;
                chk($sformatf("cmd[%0d]", i),   cmd_of(i), ec);
                chk($sformatf("addr[%0d]", i),  addr[i], ea);
                chk($sformatf("ba[%0d]", i),    ba[i], (m_idx[i] >> 19) & 3);
                chk($sformatf("dqm[%0d]", i),   dqm[i], 0);
                chk($sformatf("valid[%0d]", i), valid[i], m_valid[i]);
                chk($sformatf("done[%0d]", i),  done[i], m_done[i]);
                chk($sformatf("data[%0d]", i),  data[i], m_data[i]);
            end
        end
    end

    task automatic step();
        @(negedge sclk);
        t++;
    endtask

    task automatic wait_to(input int n);
        while (t < n) step();
    endtask

    initial begin
        int nv, nd;
        repeat (2) step();
        chk("rst cmd",   cmd_of(0), 4'b1111);
        chk("rst addr",  addr[0], 11'h400);
        chk("rst ba",    ba[0], 0);
        chk("rst valid", valid[0], 0);
        chk("rst data",  data[0], 0);
        chk("rst done",  done[0], 0);
        srst = 1'b0;

        // addr_gen with 1-bit col/row: 16 steps take bank 3 back to 0
        for (int n = 1; n <= 17; n++) begin
            ag_inc = 1'b1;
            step();
            chk("ag idx", {ag_bank, ag_row, ag_col}, n % 16);
        end
        ag_inc = 1'b0;

        // basic access, A = 1
        t = 0; rd_en = 1'b1;
        step();
        chk("basic act", cmd_of(0), 4'b0011);
        chk("basic row", addr[0], 11'h000);
        chk("basic ba",  ba[0], 0);
        rd_en = 1'b0;
        step(); chk("basic nop2", cmd_of(0), 4'b0111);
        step(); chk("basic nop3", cmd_of(0), 4'b0111);
        step(); chk("basic read", cmd_of(0), 4'b0101);
        chk("basic raddr", addr[0], 11'h400);
        wait_to(6); dq = 32'hCAFE0006;
        step();
        chk("cl2 valid", valid[1], 1);
        chk("cl2 data",  data[1], 32'hCAFE0006);
        chk("cl3 novalid", valid[0], 0);
        dq = 32'hDEADBEEF;
        step(); dq = '0;
        chk("cl3 valid", valid[0], 1);
        chk("cl3 data",  data[0], 32'hDEADBEEF);
        step(); chk("basic done9", done[0], 0);
        step(); chk("basic done10", done[0], 1);
        chk("cl2 done10", done[1], 1);
        step(); chk("basic idle11", cmd_of(0), 4'b1111);

        // back-to-back, three accesses
        srst = 1'b1; step(); srst = 1'b0;
        t = 0; rd_en = 1'b1; nv = 0;
        repeat (35) begin
            step();
            if (valid[0]) nv++;
            if (t == 1 || t == 12 || t == 23) chk("b2b act", cmd_of(0), 4'b0011);
            if (t == 11 || t == 22) chk("b2b idle", cmd_of(0), 4'b1111);
            if (t == 4)  chk("b2b rd0", addr[0], 11'h400);
            if (t == 15) chk("b2b rd1", addr[0], 11'h401);
            if (t == 26) chk("b2b rd2", addr[0], 11'h402);
            if (t == 23) rd_en = 1'b0;
        end
        chk("b2b strobes", nv, 3);

        // column wrap into row 1
        srst = 1'b1; step(); srst = 1'b0;
        t = 0; rd_en = 1'b1;
        wait_to(2809);
        chk("wrap read", cmd_of(0), 4'b0101);
        chk("wrap raddr", addr[0], 11'h4FF);
        wait_to(2817);
        chk("wrap act", cmd_of(0), 4'b0011);
        chk("wrap row", addr[0], 11'h001);
        rd_en = 1'b0;
        wait_to(2820);
        chk("wrap raddr2", addr[0], 11'h400);
        wait_to(2832);

        // reset during CL_WAIT
        srst = 1'b1; step(); srst = 1'b0;
        t = 0; rd_en = 1'b1;
        step(); rd_en = 1'b0;
        wait_to(5);
        chk("mid clwait", cmd_of(0), 4'b0111);
        srst = 1'b1; dq = 32'h12345678;
        step(); srst = 1'b0;
        chk("mid cmd", cmd_of(0), 4'b1111);
        chk("mid cmd2", cmd_of(1), 4'b1111);
        nv = 0; nd = 0;
        repeat (10) begin
            step();
            if (valid[0] || valid[1]) nv++;
            if (done[0] || done[1]) nd++;
        end
        chk("mid novalid", nv, 0);
        chk("mid nodone", nd, 0);
        rd_en = 1'b1;
        step(); rd_en = 1'b0;
        chk("mid act", cmd_of(0), 4'b0011);
        chk("mid row", addr[0], 11'h000);
        wait_to(20);
        chk("mid raddr", addr[0], 11'h400);
        wait_to(30);

        // randomized traffic with occasional resets
        repeat (3000) begin
            rd_en = ($urandom_range(0, 9) < 6);
            dq    = $urandom;
            srst  = ($urandom_range(0, 299) == 0);
            step();
        end
        srst = 1'b0; rd_en = 1'b0;
        repeat (15) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
